// File: rtl/rv32i_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM states and
// the request legality rule used when a request is presented in IDLE.
package rv32i_lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StRdWait,
      StDone
   } lsu_state_e;

   // Exactly one of ld/st, a funct3 valid for that op, and natural alignment.
   function automatic logic access_legal(input logic       ld,
                                         input logic       st,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
      logic ok;
      if (st) begin
         ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
      end else begin
         ok = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
              (funct3 == F3_LBU) || (funct3 == F3_LHU);
      end
      if ((funct3[1:0] == 2'b01) && addr_lo[0]) ok = 1'b0;
      if ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00)) ok = 1'b0;
      return ok && (ld ^ st);
   endfunction

endpackage

// File: rtl/rv32i_lsu_align.sv
// Lane steering for the LSU: byte enables, store data replication and
// load data extraction with sign/zero extension.
module rv32i_lsu_align
   import rv32i_lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  byteenable,
   output logic [31:0] wdata_rep,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   always_comb begin
      byteenable = 4'hF;
      wdata_rep  = wdata;
      case (funct3[1:0])
         2'b00: begin
            byteenable = 4'b0001 << addr_lo;
            wdata_rep  = {4{wdata[7:0]}};
         end
         2'b01: begin
            byteenable = 4'b0011 << {addr_lo[1], 1'b0};
            wdata_rep  = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      shifted = rdata >> {addr_lo, 3'b000};
      ld_data = shifted;
      case (funct3)
         F3_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_LBU:  ld_data = {24'h0, shifted[7:0]};
         F3_LHU:  ld_data = {16'h0, shifted[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one access at a time on a waitrequest/readdatavalid bus,
// stalling the pipeline until the access completes, with optional bus timeout.
module rv32i_lsu
   import rv32i_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ld,
   input  logic        st,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [4:0]  rd_idx_in,
   output logic        stall,
   output logic        ld_valid,
   output logic [4:0]  ld_rd_idx,
   output logic [31:0] ld_data,
   output logic        access_err,
   output logic [31:0] err_addr,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write,
   output logic [3:0]  mem_byteenable,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata,
   input  logic        mem_waitrequest,
   input  logic        mem_readdatavalid
);

   lsu_state_e  state;
   logic        is_ld_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  funct3_q;
   logic [4:0]  rd_idx_q;
   logic        mem_read_q;
   logic        mem_write_q;
   logic        ld_valid_q;
   logic        err_q;
   logic [31:0] ld_data_q;
   logic [31:0] err_addr_q;
   logic [15:0] tmo_cnt;

   logic        accept;
   logic        req_err;
   logic        tmo_hit;
   logic [3:0]  be;
   logic [31:0] wdata_rep;
   logic [31:0] ld_fmt;

   rv32i_lsu_align u_align (
      .funct3     (funct3_q),
      .addr_lo    (addr_q[1:0]),
      .wdata      (wdata_q),
      .rdata      (mem_readdata),
      .byteenable (be),
      .wdata_rep  (wdata_rep),
      .ld_data    (ld_fmt)
   );

   always_comb begin
      accept  = (state == StIdle) && access_legal(ld, st, funct3, addr[1:0]);
      req_err = (state == StIdle) && (ld || st) && !accept;
      // tmo_cnt holds the cycles already spent, so this fires on the final allowed cycle.
      tmo_hit = (TIMEOUT_CYCLES != 0) &&
                (({1'b0, tmo_cnt} + 17'd1) == 17'(TIMEOUT_CYCLES));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= StIdle;
         is_ld_q     <= 1'b0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         funct3_q    <= 3'b000;
         rd_idx_q    <= 5'd0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         ld_valid_q  <= 1'b0;
         err_q       <= 1'b0;
         ld_data_q   <= 32'h0;
         err_addr_q  <= 32'h0;
         tmo_cnt     <= 16'd0;
      end else begin
         ld_valid_q <= 1'b0;
         err_q      <= 1'b0;
         unique case (state)
            StIdle: begin
               if (accept) begin
                  is_ld_q     <= ld;
                  addr_q      <= addr;
                  wdata_q     <= wdata;
                  funct3_q    <= funct3;
                  rd_idx_q    <= rd_idx_in;
                  mem_read_q  <= ld;
                  mem_write_q <= st;
                  tmo_cnt     <= 16'd0;
                  state       <= StReq;
               end
            end
            StReq: begin
               tmo_cnt <= tmo_cnt + 16'd1;
               if (!mem_waitrequest) begin
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  state       <= is_ld_q ? StRdWait : StDone;
               end else if (tmo_hit) begin
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  err_q       <= 1'b1;
                  err_addr_q  <= addr_q;
                  state       <= StDone;
               end
            end
            StRdWait: begin
               tmo_cnt <= tmo_cnt + 16'd1;
               if (mem_readdatavalid) begin
                  ld_data_q  <= ld_fmt;
                  ld_valid_q <= 1'b1;
                  state      <= StDone;
               end else if (tmo_hit) begin
                  err_q      <= 1'b1;
                  err_addr_q <= addr_q;
                  state      <= StDone;
               end
            end
            StDone: state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

   assign stall          = (state == StReq) || (state == StRdWait) || accept;
   assign ld_valid       = ld_valid_q;
   assign ld_rd_idx      = rd_idx_q;
   assign ld_data        = ld_data_q;
   assign access_err     = req_err || err_q;
   assign err_addr       = req_err ? addr : err_addr_q;
   assign mem_addr       = {addr_q[31:2], 2'b00};
   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;
   assign mem_byteenable = (mem_read_q || mem_write_q) ? be : 4'h0;
   assign mem_writedata  = wdata_rep;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Self-checking bench for rv32i_lsu: directed table, random legal/illegal accesses
// against a byte-level reference model, and timeout/reset corner sequences.
module tb_rv32i_lsu;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ld = 1'b0, st = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = 32'h0, wdata = 32'h0;
   logic [4:0]  rd_idx_in = 5'd0;
   logic        stall, ld_valid, access_err, mem_read, mem_write;
   logic [4:0]  ld_rd_idx;
   logic [31:0] ld_data, err_addr, mem_addr, mem_writedata;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_readdata = 32'h0;
   logic        mem_waitrequest = 1'b0, mem_readdatavalid = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rv32i_lsu #(.TIMEOUT_CYCLES(8)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .ld                (ld),
      .st                (st),
      .funct3            (funct3),
      .addr              (addr),
      .wdata             (wdata),
      .rd_idx_in         (rd_idx_in),
      .stall             (stall),
      .ld_valid          (ld_valid),
      .ld_rd_idx         (ld_rd_idx),
      .ld_data           (ld_data),
      .access_err        (access_err),
      .err_addr          (err_addr),
      .mem_addr          (mem_addr),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .mem_byteenable    (mem_byteenable),
      .mem_writedata     (mem_writedata),
      .mem_readdata      (mem_readdata),
      .mem_waitrequest   (mem_waitrequest),
      .mem_readdatavalid (mem_readdatavalid)
   );

   typedef struct {
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [4:0]  rd;
      int          w;
      int          d;
      logic        exp_err;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      logic [31:0] exp_ld;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: access size in bytes, legality, lanes and data by byte arithmetic.
   function automatic int unsigned size_of(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic model_legal(input logic l, input logic s, input logic [2:0] f3,
                                        input logic [31:0] a);
      if (l == s) return 1'b0;
      if (s && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
      if (l && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
      return (a % size_of(f3)) == 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
      int unsigned sz = size_of(f3);
      int unsigned off = a % 4;
      logic [3:0] be = 4'h0;
      for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + sz);
      return be;
   endfunction

   function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wd);
      int unsigned sz = size_of(f3);
      logic [31:0] r = 32'h0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] rdata);
      int unsigned sz = size_of(f3);
      int unsigned off = a % 4;
      longint val = 0;
      for (int k = 0; k < sz; k++) val = val + (longint'(rdata[8*(off+k) +: 8]) << (8*k));
      if (!f3[2] && sz < 4 && val >= (longint'(1) << (8*sz - 1))) val = val - (longint'(1) << (8*sz));
      return val[31:0];
   endfunction

   function automatic vec_t mk(input logic l, input logic s, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rdat, input logic [4:0] rd, input int w,
                               input int d, input logic e, input logic [3:0] be,
                               input logic [31:0] ewd, input logic [31:0] eld);
      vec_t v;
      v.ld = l; v.st = s; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rdat; v.rd = rd;
      v.w = w; v.d = d; v.exp_err = e; v.exp_be = be; v.exp_wd = ewd; v.exp_ld = eld;
      return v;
   endfunction

   task automatic clear_inputs();
      ld = 1'b0; st = 1'b0; mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0;
   endtask

   // Called at a negedge with the DUT idle; leaves it at a negedge, idle again.
   task automatic run_vec(input vec_t v);
      int wl, acc_cyc, stall_n, strobe_n, valid_n, bus_bad, err_n;
      logic fin;
      logic [31:0] got_data;
      logic [4:0] got_rd;
      ld = v.ld; st = v.st; funct3 = v.f3; addr = v.addr; wdata = v.wdata; rd_idx_in = v.rd;
      if (v.exp_err) begin
         #1;
         chk("illegal_err", 32'(access_err), 32'd1);
         chk("illegal_err_addr", err_addr, v.addr);
         chk("illegal_quiet", {29'h0, stall, mem_read, mem_write}, 32'h0);
         @(negedge clk);
         clear_inputs();
         #1;
         chk("illegal_stay_idle", {29'h0, stall, mem_read, mem_write}, 32'h0);
         return;
      end
      wl = v.w; acc_cyc = -1; stall_n = 0; strobe_n = 0; valid_n = 0; bus_bad = 0; err_n = 0;
      fin = 1'b0; got_data = 32'h0; got_rd = 5'd0;
      for (int c = 0; c < 40 && !fin; c++) begin
         if (c > 0) @(negedge clk);
         mem_waitrequest = (mem_read || mem_write) && (wl > 0);
         if ((mem_read || mem_write) && wl == 0 && acc_cyc < 0) acc_cyc = c;
         mem_readdatavalid = v.ld && (acc_cyc >= 0) && (c == acc_cyc + 1 + v.d);
         mem_readdata = mem_readdatavalid ? v.rdata : $urandom;
         #1;
         if (mem_read || mem_write) begin
            strobe_n++;
            if (mem_read != v.ld || mem_write != v.st || mem_addr != {v.addr[31:2], 2'b00} ||
                mem_byteenable != v.exp_be || (v.st && mem_writedata != v.exp_wd)) bus_bad++;
            if (wl > 0) wl--;
         end
         if (access_err) err_n++;
         if (ld_valid) begin
            valid_n++; got_data = ld_data; got_rd = ld_rd_idx;
         end
         if (stall) stall_n++;
         else if (c > 0) fin = 1'b1;
      end
      chk("access_completes", 32'(fin), 32'd1);
      chk("stall_cycles", 32'(stall_n), v.st ? 32'(2 + v.w) : 32'(3 + v.w + v.d));
      chk("strobe_cycles", 32'(strobe_n), 32'(1 + v.w));
      chk("bus_fields", 32'(bus_bad), 32'd0);
      chk("no_error", 32'(err_n), 32'd0);
      chk("ld_valid_count", 32'(valid_n), v.ld ? 32'd1 : 32'd0);
      if (v.ld) begin
         chk("ld_data", got_data, v.exp_ld);
         chk("ld_rd_idx", 32'(got_rd), 32'(v.rd));
      end
      @(negedge clk);
      clear_inputs();
      #1;
      chk("idle_after", {29'h0, stall, ld_valid, mem_read || mem_write}, 32'h0);
   endtask

   // Load with readdatavalid never arriving, or store with waitrequest held forever.
   task automatic run_timeout(input logic is_ld);
      int stall_n, valid_n, err_cyc;
      logic [31:0] a;
      logic [31:0] eaddr;
      logic strobe_at_err;
      a = is_ld ? 32'h40 : 32'h80;
      ld = is_ld; st = !is_ld; funct3 = is_ld ? 3'b001 : 3'b010; addr = a;
      wdata = 32'h5555_AAAA; rd_idx_in = 5'd7;
      stall_n = 0; valid_n = 0; err_cyc = -1; eaddr = 32'h0; strobe_at_err = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) @(negedge clk);
         mem_waitrequest = !is_ld;
         mem_readdatavalid = 1'b0;
         #1;
         if (stall) stall_n++;
         if (ld_valid) valid_n++;
         if (access_err && err_cyc < 0) begin
            err_cyc = c; eaddr = err_addr; strobe_at_err = mem_read || mem_write;
         end
         if (!stall && c > 0) break;
      end
      chk("tmo_stall_cycles", 32'(stall_n), 32'd9);
      chk("tmo_err_cycle", 32'(err_cyc), 32'd9);
      chk("tmo_err_addr", eaddr, a);
      chk("tmo_strobe_dropped", 32'(strobe_at_err), 32'd0);
      chk("tmo_no_ld_valid", 32'(valid_n), 32'd0);
      @(negedge clk);
      clear_inputs();
      #1;
      chk("tmo_back_idle", {29'h0, stall, access_err, mem_read || mem_write}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t tbl[$];
      vec_t v;
      int unsigned sz, off, op;

      repeat (3) @(negedge clk);
      #1;
      chk("reset_ctrl", {27'h0, stall, ld_valid, access_err, mem_read, mem_write}, 32'h0);
      chk("reset_ld_data", ld_data, 32'h0);
      chk("reset_err_addr", err_addr, 32'h0);
      chk("reset_mem_addr", mem_addr, 32'h0);
      chk("reset_mem_wdata", mem_writedata, 32'h0);
      chk("reset_idx_be", {23'h0, ld_rd_idx, mem_byteenable}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      //          ld  st  f3      addr         wdata         rdata         rd  w  d err be    exp_wd        exp_ld
      tbl.push_back(mk(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        5'd0, 0, 0, 0, 4'hF, 32'hDEADBEEF, 32'h0));
      tbl.push_back(mk(1, 0, 3'b000, 32'h203, 32'h0,        32'h80FF0000, 5'd5, 0, 0, 0, 4'h8, 32'h0, 32'hFFFFFF80));
      tbl.push_back(mk(1, 0, 3'b100, 32'h203, 32'h0,        32'h80FF0000, 5'd0, 0, 0, 0, 4'h8, 32'h0, 32'h00000080));
      tbl.push_back(mk(0, 1, 3'b001, 32'h12,  32'h1234ABCD, 32'h0,        5'd0, 3, 0, 0, 4'hC, 32'hABCDABCD, 32'h0));
      tbl.push_back(mk(1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        5'd1, 0, 0, 1, 4'h0, 32'h0, 32'h0));
      tbl.push_back(mk(1, 1, 3'b010, 32'h200, 32'h0,        32'h0,        5'd1, 0, 0, 1, 4'h0, 32'h0, 32'h0));
      tbl.push_back(mk(1, 0, 3'b001, 32'h43,  32'h0,        32'h0,        5'd2, 0, 0, 1, 4'h0, 32'h0, 32'h0));
      tbl.push_back(mk(0, 1, 3'b100, 32'h44,  32'h0,        32'h0,        5'd2, 0, 0, 1, 4'h0, 32'h0, 32'h0));
      tbl.push_back(mk(1, 0, 3'b101, 32'h42,  32'h0,        32'h80011234, 5'd9, 0, 2, 0, 4'hC, 32'h0, 32'h00008001));
      tbl.push_back(mk(1, 0, 3'b001, 32'h42,  32'h0,        32'h80011234, 5'd31, 1, 0, 0, 4'hC, 32'h0, 32'hFFFF8001));
      tbl.push_back(mk(0, 1, 3'b000, 32'h1,   32'h000000A5, 32'h0,        5'd0, 0, 0, 0, 4'h2, 32'hA5A5A5A5, 32'h0));
      tbl.push_back(mk(1, 0, 3'b010, 32'h44,  32'h0,        32'hCAFEF00D, 5'd3, 1, 1, 0, 4'hF, 32'h0, 32'hCAFEF00D));
      foreach (tbl[i]) run_vec(tbl[i]);

      run_timeout(1'b1);
      run_timeout(1'b0);

      // Reset while waiting for read data; the late readdatavalid must be ignored.
      ld = 1'b1; st = 1'b0; funct3 = 3'b010; addr = 32'h10; rd_idx_in = 5'd4;
      @(negedge clk);
      mem_waitrequest = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_in_rdwait_stall", 32'(stall), 32'd1);
      reset_n = 1'b0; ld = 1'b0;
      @(negedge clk);
      reset_n = 1'b1; mem_readdatavalid = 1'b1; mem_readdata = 32'h12345678;
      #1;
      chk("rst_abort_outputs", {29'h0, stall, ld_valid, mem_read || mem_write}, 32'h0);
      @(negedge clk);
      mem_readdatavalid = 1'b0;
      #1;
      chk("rst_late_rdv_ignored", {29'h0, stall, ld_valid, access_err}, 32'h0);
      @(negedge clk);

      for (int n = 0; n < 40; n++) begin
         op = $urandom_range(0, 9);
         v.ld = (op != 9 && op < 6) || op == 0;
         v.st = op >= 6 || op == 0;
         v.f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) v.f3 = v.st ? 3'($urandom_range(0, 2)) : v.f3 & 3'b101;
         sz = size_of(v.f3) > 4 ? 4 : size_of(v.f3);
         off = $urandom_range(0, 3);
         if ($urandom_range(0, 3) != 0) off = off - (off % sz);
         v.addr = ($urandom & 32'hFFFF_FFFC) | 32'(off);
         v.wdata = $urandom; v.rdata = $urandom; v.rd = 5'($urandom_range(0, 31));
         v.w = $urandom_range(0, 2); v.d = $urandom_range(0, 2);
         v.exp_err = !model_legal(v.ld, v.st, v.f3, v.addr);
         v.exp_be = v.exp_err ? 4'h0 : model_be(v.f3, v.addr);
         v.exp_wd = v.exp_err ? 32'h0 : model_wd(v.f3, v.wdata);
         v.exp_ld = v.exp_err ? 32'h0 : model_load(v.f3, v.addr, v.rdata);
         run_vec(v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
